// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared state encoding and constants for the program loader
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } loader_state_e;

    localparam int          BYTES_PER_WORD    = 4;
    // Also used by the fetch-side program memory for its address correction.
    localparam logic [31:0] TEXT_BASE_ADDRESS = 32'h0040_0000;

endpackage

// File: rtl/program_loader_assembler.sv
// rtl/program_loader_assembler.sv - big-endian byte-to-word assembler
module byte_assembler
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        last_byte_o,
    output logic        word_ready_o
);

    logic [1:0]  byte_cnt_q;
    logic [31:0] word_q;
    logic        word_ready_q;

    // High while the byte being shifted in completes the current word.
    assign last_byte_o  = (byte_cnt_q == 2'(BYTES_PER_WORD - 1));
    assign word_o       = word_q;
    assign word_ready_o = word_ready_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt_q   <= 2'd0;
            word_q       <= 32'd0;
            word_ready_q <= 1'b0;
        end else if (clear_i) begin
            byte_cnt_q   <= 2'd0;
            word_ready_q <= 1'b0;
        end else if (shift_i) begin
            word_q       <= {word_q[23:0], byte_i};
            byte_cnt_q   <= byte_cnt_q + 2'd1;
            word_ready_q <= last_byte_o;
        end
    end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a program image into program memory while holding the CPU
module program_loader
    import program_loader_pkg::*;
#(
    parameter int          MEMORY_DEPTH = 32,
    parameter int          DATA_WIDTH   = 32,
    parameter logic [31:0] BASE_ADDRESS = TEXT_BASE_ADDRESS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [15:0]           word_count_i,
    input  logic [7:0]            byte_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    output logic                  mem_write_o,
    output logic [DATA_WIDTH-1:0] mem_address_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  cpu_hold_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam logic [DATA_WIDTH-1:0] ADDR_STEP = DATA_WIDTH'(BYTES_PER_WORD);

    loader_state_e         state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           remaining_q, remaining_d;

    logic        asm_clear;
    logic        asm_shift;
    logic        asm_last_byte;
    logic        asm_word_ready;
    logic [31:0] asm_word;

    byte_assembler u_assembler (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (asm_clear),
        .shift_i      (asm_shift),
        .byte_i       (byte_i),
        .word_o       (asm_word),
        .last_byte_o  (asm_last_byte),
        .word_ready_o (asm_word_ready)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= BASE_ADDRESS;
            remaining_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        asm_clear   = 1'b0;
        asm_shift   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) begin
                    if (word_count_i == 16'd0) begin
                        state_d = ST_DONE;
                    end else if ({16'd0, word_count_i} > MEMORY_DEPTH) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d     = ST_RECV;
                        remaining_d = word_count_i;
                        addr_d      = BASE_ADDRESS;
                        asm_clear   = 1'b1;
                    end
                end
            end
            ST_RECV: begin
                if (byte_valid_i) begin
                    asm_shift = 1'b1;
                    if (asm_last_byte) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                remaining_d = remaining_q - 16'd1;
                // Address is held on the last word so it never points past the image.
                if (remaining_q == 16'd1) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RECV;
                    addr_d  = addr_q + ADDR_STEP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign byte_ready_o  = (state_q == ST_RECV);
    assign mem_write_o   = (state_q == ST_WRITE) && asm_word_ready;
    assign mem_address_o = addr_q;
    assign mem_data_o    = DATA_WIDTH'(asm_word);
    assign cpu_hold_o    = (state_q != ST_DONE);
    assign busy_o        = (state_q == ST_RECV) || (state_q == ST_WRITE);
    assign done_o        = (state_q == ST_DONE);
    assign error_o       = (state_q == ST_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader
module tb_program_loader;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [15:0] word_count_i = 16'd0;
    logic [7:0]  byte_i = 8'd0;
    logic        byte_valid_i = 1'b0;
    logic        byte_ready_o;
    logic        mem_write_o;
    logic [31:0] mem_address_o;
    logic [31:0] mem_data_o;
    logic        cpu_hold_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;

    program_loader dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start_i),
        .word_count_i  (word_count_i),
        .byte_i        (byte_i),
        .byte_valid_i  (byte_valid_i),
        .byte_ready_o  (byte_ready_o),
        .mem_write_o   (mem_write_o),
        .mem_address_o (mem_address_o),
        .mem_data_o    (mem_data_o),
        .cpu_hold_o    (cpu_hold_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int count;
        bit stall;
        bit pulse;
        int exp_latency;
    } vec_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && mem_write_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%0h/%0h expected=none", mem_address_o, mem_data_o);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", mem_address_o, e.addr);
                check("write_data", mem_data_o, e.data);
            end
        end
    end

    task automatic do_start(input int n);
        start_i = 1'b1;
        word_count_i = 16'(n);
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit hs;
        int n;
        hs = 1'b0;
        n = 0;
        byte_i = b;
        byte_valid_i = 1'b1;
        do begin
            @(negedge clk);
            hs = byte_ready_o;
            @(posedge clk); #1;
            n++;
        end while (!hs && n < 50);
        byte_valid_i = 1'b0;
        if (!hs) check("byte_handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int first, input int last,
                             input bit stall, input bit pulse);
        for (int b = first; b <= last; b++) begin
            if (pulse && b == 0) begin
                start_i = 1'b1;
                word_count_i = 16'd5;
            end
            send_byte(w[31 - 8*b -: 8]);
            start_i = 1'b0;
            if (stall && b == 1) begin
                repeat (3) begin @(posedge clk); #1; end
            end
        end
    endtask

    function automatic logic [31:0] img_word(input int i);
        if (i == 0) return 32'h2008_0005;
        if (i == 1) return 32'hAC09_0000;
        return $urandom;
    endfunction

    task automatic run_load(input int n, input bit stall, input bit pulse, input int exp_lat);
        int k0;
        logic [31:0] w;
        do_start(n);
        k0 = cyc;
        for (int i = 0; i < n; i++) begin
            w = img_word(i);
            exp_q.push_back('{BASE + 32'(4 * i), w});
            send_word(w, 0, 3, stall && i == 0, pulse && i == 0);
        end
        @(negedge clk);
        check("last_write_strobe", {31'd0, mem_write_o}, 32'd1);
        check("done_before_last_write", {31'd0, done_o}, 32'd0);
        check("load_latency", 32'(cyc - k0), 32'(exp_lat));
        @(posedge clk); #1;
        @(negedge clk);
        check("done_after_load", {31'd0, done_o}, 32'd1);
        check("hold_after_load", {31'd0, cpu_hold_o}, 32'd0);
        check("busy_after_load", {31'd0, busy_o}, 32'd0);
        check("error_after_load", {31'd0, error_o}, 32'd0);
        check("last_address", mem_address_o, BASE + 32'(4 * (n - 1)));
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_values();
        check("rst_ready", {31'd0, byte_ready_o}, 32'd0);
        check("rst_write", {31'd0, mem_write_o}, 32'd0);
        check("rst_addr", mem_address_o, BASE);
        check("rst_data", mem_data_o, 32'd0);
        check("rst_hold", {31'd0, cpu_hold_o}, 32'd1);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_error", {31'd0, error_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        vec_t vecs[5];
        vecs[0] = '{1,  1'b0, 1'b0, 4};
        vecs[1] = '{2,  1'b0, 1'b0, 9};
        vecs[2] = '{2,  1'b1, 1'b0, 12};
        vecs[3] = '{32, 1'b0, 1'b0, 159};
        vecs[4] = '{2,  1'b0, 1'b1, 9};

        @(posedge clk); #1;
        check_reset_values();
        reset = 1'b0;

        // Zero-length image completes immediately.
        do_start(0);
        @(negedge clk);
        check("zero_done", {31'd0, done_o}, 32'd1);
        check("zero_hold", {31'd0, cpu_hold_o}, 32'd0);
        check("zero_busy", {31'd0, busy_o}, 32'd0);
        @(posedge clk); #1;

        // Oversized image is rejected without writes.
        do_start(33);
        @(negedge clk);
        check("err_flag", {31'd0, error_o}, 32'd1);
        check("err_hold", {31'd0, cpu_hold_o}, 32'd1);
        check("err_done", {31'd0, done_o}, 32'd0);
        check("err_busy", {31'd0, busy_o}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", {31'd0, error_o}, 32'd1);

        for (int v = 0; v < 5; v++) begin
            run_load(vecs[v].count, vecs[v].stall, vecs[v].pulse, vecs[v].exp_latency);
        end

        // Reset after 6 bytes of a 3-word load.
        do_start(3);
        exp_q.push_back('{BASE, 32'h2008_0005});
        send_word(32'h2008_0005, 0, 3, 1'b0, 1'b0);
        send_word(32'hAC09_0000, 0, 1, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check_reset_values();
        check("mid_reset_writes", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_load(1, 1'b0, 1'b0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
